pwm_multi_ch: RTL
=================

# pwm_multi_ch

Parametrised multi-channel PWM generator with a per-channel heartbeat watchdog, glitch-free duty updates, optional duty slew limiting and safe direction reversal. It replaces single-channel PWM instances on the FPGA motor-drive path. It sits between the command register bank and the motor-driver pins: PWM, direction and driver-enable per channel.

## Interface
- `CHANNELS`, default 4: number of independent channels, 1..16.
- `WIDTH`, default 11: duty and period-counter width in bits; PWM period is 2^WIDTH ticks.
- `PRESCALE`, default 1: number of clk cycles per PWM tick, ≥1.
- `WD_TIMEOUT`, default 4000000: heartbeat timeout in clk cycles, ≥2.
- `RAMP_STEP`, default 0: maximum change of the active duty per period; 0 disables slew limiting.

- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd`, in, CHANNELS*(WIDTH+2): per-channel slice c at [(c+1)*(WIDTH+2)-1 : c*(WIDTH+2)], laid out as {hb, dir, duty[WIDTH-1:0]}.
- `pwm_o`, out, CHANNELS: PWM outputs.
- `dir_o`, out, CHANNELS: applied direction.
- `enable_o`, out, CHANNELS: driver enable, driven from the watchdog.
- `fault_o`, out, CHANNELS: sticky watchdog-timeout flag.
- `period_start_o`, out, 1: one-clk pulse at each period boundary.

## Operation
- **Prescaler:** counts 0..PRESCALE-1; `tick` asserts when it equals PRESCALE-1. With PRESCALE=1, tick fires every cycle.
- **Period counter** `pcnt` (WIDTH bits, shared by all channels):
  - increments on tick and wraps from 2^WIDTH-1 to 0;
  - "boundary" is the tick on which `pcnt` wraps to 0;
  - `period_start_o` = 1 for that single clk.
- **Per-channel state:** `active` duty (WIDTH bits), `dir_o`, watchdog counter, `prev_hb`.
- **Boundary update, in this order:**
  1. `target` = cmd duty if cmd dir == `dir_o`, else 0.
  2. If `active` == 0 and cmd dir != `dir_o`, set `dir_o` to cmd dir and `active` stays 0. A reversal therefore always spends at least one full period at zero duty.
  3. Otherwise, if RAMP_STEP == 0, `active` = `target`.
  4. Otherwise, `active` moves toward `target` by min(RAMP_STEP, |target − active|). Arithmetic is in WIDTH+1 bits, with no overshoot and no wrap.
  5. cmd duty is ignored between boundaries.
- **PWM output:** `pwm_o` = `enable_o` && (`pcnt` < `active`).
  - `active` = 0 gives constant low.
  - `active` = 2^WIDTH−1 gives high for 2^WIDTH−1 of 2^WIDTH ticks.
- **Watchdog (per channel, evaluated every clk):**
  - **Toggle** (hb != `prev_hb`): `prev_hb` ← hb, counter ← 0, `enable_o` ← 1.
  - **No toggle, counter == WD_TIMEOUT−1:** `enable_o` ← 0, `fault_o` ← 1, `active` ← 0 immediately (not deferred to a boundary), counter holds.
  - **No toggle, otherwise:** counter increments; it saturates and never wraps.
  - A toggle re-arms `enable_o`. Ramp then restarts from 0.
  - `fault_o` clears only on `rst`.
  - Counter width is $clog2(WD_TIMEOUT).
- **Reset:** while `rst` is sampled high, all registers clear.
  - `pwm_o`=0, `dir_o`=0, `enable_o`=0, `fault_o`=0, `period_start_o`=0.
  - `pcnt`=0, prescaler=0, `active`=0, `prev_hb`=0, watchdog counters=0.
  - Reset mid-period aborts the period. After release the first tick moves `pcnt` to 1.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- **Heartbeat:** a hb toggle sampled at edge N gives `enable_o`=1 after edge N.
- **Timeout:** with the last toggle sampled at edge N and no further toggle, `enable_o`=0 and `fault_o`=1 after edge N+WD_TIMEOUT. `pwm_o`=0 after that same edge.
- `pwm_o` reflects the `pcnt`/`active`/`enable_o` values present after the same edge. All channels switch on the same edge.
- **Duty change:** takes effect at the first boundary after cmd changes. Worst-case latency is PRESCALE*2^WIDTH clk.
- **Timeout coinciding with a boundary:** the timeout wins, so `active`=0.
- **Toggle coinciding with a timeout:** the toggle wins, and `enable_o` stays 1.
- **Period length:** exactly PRESCALE*2^WIDTH clk between `period_start_o` pulses.

## Test plan
Default bench: CHANNELS=2, WIDTH=4, PRESCALE=2, WD_TIMEOUT=100.

1. **Basic duty:** RAMP_STEP=0, ch0 duty=5, hb toggled every 50 clk → after the first boundary, `pwm_o[0]` high 10 clk / low 22 clk per 32-clk period. `period_start_o` pulses every 32 clk.
2. **Glitch-free update:** duty changed 5→12 mid-period → current period keeps 5. The next period, starting at the boundary, shows 24 clk high.
3. **Ramp:** RAMP_STEP=3, target 0→10 → `active` 3,6,9,10 on successive boundaries. Then target 10→0 gives 7,4,1,0.
4. **Direction reversal:** RAMP_STEP=0, dir 0, duty 8, then cmd dir=1 duty=8 → next boundary `active`=0; following boundary `dir_o`=1; one boundary later `active`=8.
5. **Watchdog:** hb toggle at edge N, then held → `enable_o`/`pwm_o` low and `fault_o`=1 after edge N+100. A new toggle restores `enable_o` next edge; `fault_o` stays 1 until `rst`.
6. **Reset mid-operation:** `rst` asserted during the high phase → all outputs 0 after that edge. After release, `pwm_o` stays 0 until a hb toggle and the next boundary.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaler/period counter, per-channel duty
// with boundary-only updates, optional slew limiting, safe reversal and heartbeat watchdog.
module pwm_multi_ch #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 11,
    parameter int PRESCALE   = 1,
    parameter int WD_TIMEOUT = 4000000,
    parameter int RAMP_STEP  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*(WIDTH+2)-1:0] cmd,
    output logic [CHANNELS-1:0]          pwm_o,
    output logic [CHANNELS-1:0]          dir_o,
    output logic [CHANNELS-1:0]          enable_o,
    output logic [CHANNELS-1:0]          fault_o,
    output logic                         period_start_o
);

    localparam int PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WD_W     = $clog2(WD_TIMEOUT);
    localparam int RAMP_SAT = (RAMP_STEP > (1 << WIDTH)) ? (1 << WIDTH) : RAMP_STEP;

    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WD_TIMEOUT - 1);
    localparam logic [WIDTH:0]   RAMP_W  = (WIDTH + 1)'(RAMP_SAT);

    logic [PSC_W-1:0]    psc_q, psc_d;
    logic [WIDTH-1:0]    pcnt_q, pcnt_d;
    logic                period_start_q, period_start_d;
    logic                tick;
    logic                boundary;

    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [WD_W-1:0]     wd_q [CHANNELS];
    logic [WD_W-1:0]     wd_d [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] fault_q, fault_d;
    logic [CHANNELS-1:0] prev_hb_q, prev_hb_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    // Step the active duty toward the target without overshooting; WIDTH+1 bits keep the
    // difference and the sum free of wrap.
    function automatic logic [WIDTH-1:0] ramp_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] cur_w;
        logic [WIDTH:0] tgt_w;
        logic [WIDTH:0] diff;
        cur_w = {1'b0, cur};
        tgt_w = {1'b0, tgt};
        if (RAMP_STEP == 0) begin
            return tgt;
        end
        if (tgt_w >= cur_w) begin
            diff = tgt_w - cur_w;
            return (diff > RAMP_W) ? WIDTH'(cur_w + RAMP_W) : tgt;
        end
        diff = cur_w - tgt_w;
        return (diff > RAMP_W) ? WIDTH'(cur_w - RAMP_W) : tgt;
    endfunction

    always_comb begin
        tick           = (psc_q == PSC_MAX);
        psc_d          = tick ? '0 : psc_q + 1'b1;
        boundary       = tick && (pcnt_q == '1);
        pcnt_d         = tick ? pcnt_q + 1'b1 : pcnt_q;
        period_start_d = boundary;
    end

    always_comb begin
        dir_d     = dir_q;
        en_d      = en_q;
        fault_d   = fault_q;
        prev_hb_d = prev_hb_q;
        pwm_d     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            logic [WIDTH-1:0] duty_c;
            logic [WIDTH-1:0] target_c;
            logic             dir_c;
            logic             hb_c;
            duty_c      = cmd[c*(WIDTH+2) +: WIDTH];
            dir_c       = cmd[c*(WIDTH+2) + WIDTH];
            hb_c        = cmd[c*(WIDTH+2) + WIDTH + 1];
            target_c    = (dir_c == dir_q[c]) ? duty_c : '0;
            active_d[c] = active_q[c];
            wd_d[c]     = wd_q[c];

            // A reversal only commits once the channel has already settled at zero duty.
            if (boundary) begin
                if ((active_q[c] == '0) && (dir_c != dir_q[c])) begin
                    dir_d[c] = dir_c;
                end else begin
                    active_d[c] = ramp_toward(active_q[c], target_c);
                end
            end

            // Timeout overrides any boundary update made above.
            if (hb_c != prev_hb_q[c]) begin
                prev_hb_d[c] = hb_c;
                wd_d[c]      = '0;
                en_d[c]      = 1'b1;
            end else if (wd_q[c] == WD_MAX) begin
                en_d[c]      = 1'b0;
                fault_d[c]   = 1'b1;
                active_d[c]  = '0;
            end else begin
                wd_d[c]      = wd_q[c] + 1'b1;
            end

            pwm_d[c] = en_d[c] && (pcnt_d < active_d[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_q          <= '0;
            pcnt_q         <= '0;
            period_start_q <= 1'b0;
            dir_q          <= '0;
            en_q           <= '0;
            fault_q        <= '0;
            prev_hb_q      <= '0;
            pwm_q          <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                active_q[c] <= '0;
                wd_q[c]     <= '0;
            end
        end else begin
            psc_q          <= psc_d;
            pcnt_q         <= pcnt_d;
            period_start_q <= period_start_d;
            dir_q          <= dir_d;
            en_q           <= en_d;
            fault_q        <= fault_d;
            prev_hb_q      <= prev_hb_d;
            pwm_q          <= pwm_d;
            for (int c = 0; c < CHANNELS; c++) begin
                active_q[c] <= active_d[c];
                wd_q[c]     <= wd_d[c];
            end
        end
    end

    assign pwm_o          = pwm_q;
    assign dir_o          = dir_q;
    assign enable_o       = en_q;
    assign fault_o        = fault_q;
    assign period_start_o = period_start_q;

endmodule
